// File: rtl/arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// State encoding and counter widths.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_BUSY = 2'd1,
    DATA_BUSY  = 2'd2
  } arb_state_t;

  localparam int STREAK_W = 4;
  localparam int TMO_W    = 16;

endpackage

// File: rtl/arb_priority.sv
// Winner selection between fetch and data requesters.
// Data wins unless fetch has waited out a full data streak.
module arb_priority
  import arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                f_req,
  input  logic                f_done,
  input  logic                d_req,
  input  logic                d_done,
  input  logic [STREAK_W-1:0] streak,
  output logic                f_elig,
  output logic                grant_f,
  output logic                grant_d
);

  localparam logic [STREAK_W-1:0] MAX_S =
    STREAK_W'(MAX_DATA_STREAK);

  logic d_elig;
  logic f_force;

  always_comb begin
    f_elig  = f_req & ~f_done;
    d_elig  = d_req & ~d_done;
    f_force = f_elig & (streak == MAX_S);
    grant_d = d_elig & ~f_force;
    grant_f = f_elig & ~grant_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory.
// Optional watchdog and ARB_ERR flag: define ARB_TIMEOUT_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
`ifdef ARB_TIMEOUT_EN
  output logic              ARB_ERR,
`endif
  input  logic              F_REQ,
  input  logic [ADDR_W-1:0] F_ADDR,
  output logic              F_DONE,
  output logic [DATA_W-1:0] F_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_DONE,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_READY,
  output logic              StallF,
  output logic              StallM
);

  localparam logic [STREAK_W-1:0] MAX_S =
    STREAK_W'(MAX_DATA_STREAK);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                f_done_q, f_done_d;
  logic                d_done_q, d_done_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                f_elig;
  logic                grant_f;
  logic                grant_d;
  logic                fin;
  logic [DATA_W-1:0]   fin_data;

`ifdef ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LIM =
    TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  arb_priority #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio (
    .f_req  (F_REQ),
    .f_done (f_done_q),
    .d_req  (D_REQ),
    .d_done (d_done_q),
    .streak (streak_q),
    .f_elig (f_elig),
    .grant_f(grant_f),
    .grant_d(grant_d)
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_done_d    = 1'b0;
    d_done_d    = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    fin         = 1'b0;
    fin_data    = MEM_RDATA;
`ifdef ARB_TIMEOUT_EN
    wdog_d      = wdog_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = DATA_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = D_WE;
          mem_addr_d  = D_ADDR;
          mem_wdata_d = D_WDATA;
          // streak only grows while fetch is actually waiting
          if (!f_elig)
            streak_d = '0;
          else if (streak_q != MAX_S)
            streak_d = streak_q + STREAK_W'(1);
        end else if (grant_f) begin
          state_d     = FETCH_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = F_ADDR;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      FETCH_BUSY, DATA_BUSY: begin
        if (MEM_READY) begin
          fin = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (wdog_q == TMO_LIM) begin
          fin      = 1'b1;
          fin_data = '0;
          err_d    = 1'b1;
        end else begin
          wdog_d = wdog_q + TMO_W'(1);
`endif
        end
        if (fin) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
`ifdef ARB_TIMEOUT_EN
          wdog_d    = '0;
`endif
          if (state_q == FETCH_BUSY) begin
            f_done_d  = 1'b1;
            f_rdata_d = fin_data;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = fin_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_done_q    <= f_done_d;
      d_done_q    <= d_done_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign ARB_ERR = err_q;
`endif

  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign F_DONE    = f_done_q;
  assign D_DONE    = d_done_q;
  assign F_RDATA   = f_rdata_q;
  assign D_RDATA   = d_rdata_q;
  assign StallF    = F_REQ & ~f_done_q;
  assign StallM    = D_REQ & ~d_done_q;

endmodule
